axis_frame_rx: RTL and testbench
================================

AXIS_FRAME_RX -- requirements
Module: axis_frame_rx

Interface
REQ-001 Parameter DATA_SIZE, default 12, width of one sample carried in tdata[DATA_SIZE-1:0].
REQ-002 Parameter LENGTH, default 32768, number of samples in one frame.
REQ-003 Parameter LENGTH_SIZE, default 15, width of the frame address; 2**LENGTH_SIZE >= LENGTH.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rstn  in  1  reset, asynchronous assert, active-low.
REQ-006 Start  in  1  one-cycle pulse that arms reception of one frame.
REQ-007 Abort  in  1  one-cycle pulse that returns the block to IDLE.
REQ-008 S_AXIS_tdata  in  32  stream data from the DMA MM2S channel.
REQ-009 S_AXIS_tkeep  in  4  byte enables; all-ones expected.
REQ-010 S_AXIS_tlast  in  1  end-of-frame marker.
REQ-011 S_AXIS_tvalid  in  1  source beat valid.
REQ-012 S_AXIS_tready  out  1  sink ready.
REQ-013 FramStall  in  1  frame-memory backpressure; 1 = cannot accept a write this cycle.
REQ-014 FramData  out  DATA_SIZE  sample to write.
REQ-015 FramAdd  out  LENGTH_SIZE  write address.
REQ-016 FramEn  out  1  write strobe, one cycle per sample.
REQ-017 Busy  out  1  high in RECV or DRAIN.
REQ-018 Done  out  1  one-cycle pulse on frame completion, good or bad.
REQ-019 LenErr  out  1  sticky; frame length differed from LENGTH.
REQ-020 KeepErr  out  1  sticky; a beat arrived with tkeep != 4'hF.
REQ-021 FrameCnt  out  16  count of completed frames, wraps at 65535 -> 0.

Function
REQ-022 The state machine SHALL have the states IDLE, RECV, and DRAIN.
REQ-023 IDLE -> RECV on Start; Start SHALL clear LenErr, KeepErr, and the sample counter; Start outside IDLE SHALL be ignored.
REQ-024 Beat accept condition: tvalid && tready; S_AXIS_tready = (RECV && !FramStall) || DRAIN.
REQ-025 In RECV, each accepted beat SHALL register FramData=tdata[DATA_SIZE-1:0], FramAdd=count, FramEn=1 on the next clock (latency 1); FramEn=0 otherwise.
REQ-026 The counter SHALL increment per accepted RECV beat, width LENGTH_SIZE+1, with no wrap inside a frame.
REQ-027 Accepted beat with tlast and count==LENGTH-1 SHALL move the block to IDLE, pulse Done, increment FrameCnt, and leave LenErr unchanged.
REQ-028 Accepted beat with tlast and count<LENGTH-1 (short frame) SHALL write that sample, set LenErr, pulse Done, increment FrameCnt, and move to IDLE.
REQ-029 Accepted beat with count==LENGTH-1 and no tlast (long frame) SHALL write that sample, set LenErr, and move to DRAIN.
REQ-030 DRAIN SHALL accept and discard beats with FramEn=0; on tlast it SHALL pulse Done, increment FrameCnt, and move to IDLE.
REQ-031 Any accepted beat with tkeep != 4'hF SHALL set KeepErr; the data SHALL still be handled as normal.
REQ-032 The Done pulse SHALL be aligned with the FramEn of the last written sample (both 1 cycle after the final beat).
REQ-033 Abort in any state SHALL move the block to IDLE next cycle: tready=0, FramEn=0, no Done pulse, FrameCnt unchanged, sticky flags kept.
REQ-034 Abort and Start in the same cycle: Abort SHALL win.
REQ-035 In IDLE, tready=0; beats SHALL NOT be consumed.
REQ-036 FramStall SHALL only gate tready; a beat already accepted SHALL always produce its FramEn.

Reset
REQ-037 On rstn=0 the block SHALL asynchronously go to IDLE with tready=0, FramEn=0, FramData=0, FramAdd=0, Busy=0, Done=0, LenErr=0, KeepErr=0, FrameCnt=0, and the counter cleared.
REQ-038 Reset deasserted mid-frame SHALL resume in IDLE; remaining beats SHALL be left unconsumed until the next Start.

Verification
REQ-039 LENGTH=256, Start, 256 beats tdata=i, tlast on beat 255 -> FramAdd 0..255 with FramData=i; Done once, aligned with addr 255; LenErr=0; FrameCnt=1.
REQ-040 Short frame: tlast on beat 99 -> 100 writes, LenErr=1, Done, IDLE, FrameCnt+1.
REQ-041 Long frame: 300 beats, tlast on 299 -> 256 writes, beats 256..299 drained with FramEn=0, LenErr=1, one Done after beat 299.
REQ-042 Random FramStall and tvalid gaps over a 256-beat frame -> no lost or duplicated write; FramAdd strictly sequential; tdata echoed exactly.
REQ-043 Beat 10 with tkeep=4'h7 -> KeepErr=1, sample 10 still written; the next Start clears KeepErr.
REQ-044 Abort at beat 50, then Start, then a full frame -> no Done for the aborted frame; new frame writes from FramAdd 0; FrameCnt+1 only.

Source files
------------

// File: rtl/axis_frame_rx.sv
// axis_frame_rx
// Receives one frame of samples from an AXI4-Stream source (DMA MM2S) and
// writes each sample into a frame memory at sequential addresses.
//
// Ports:
//   clk, rstn           clock, asynchronous active-low reset
//   Start, Abort        one-cycle control pulses (Abort wins over Start)
//   S_AXIS_*            AXI4-Stream slave (tdata/tkeep/tlast/tvalid/tready)
//   FramStall           frame-memory backpressure, gates tready only
//   FramData/FramAdd/FramEn  registered frame-memory write port (latency 1)
//   Busy                high while receiving or draining
//   Done                one-cycle pulse when a frame completes (good or bad)
//   LenErr, KeepErr     sticky error flags, cleared by Start
//   FrameCnt            completed-frame counter, wraps
module axis_frame_rx #(
   parameter int DATA_SIZE   = 12,
   parameter int LENGTH      = 32768,
   parameter int LENGTH_SIZE = 15
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   Start,
   input  logic                   Abort,
   input  logic [31:0]            S_AXIS_tdata,
   input  logic [3:0]             S_AXIS_tkeep,
   input  logic                   S_AXIS_tlast,
   input  logic                   S_AXIS_tvalid,
   output logic                   S_AXIS_tready,
   input  logic                   FramStall,
   output logic [DATA_SIZE-1:0]   FramData,
   output logic [LENGTH_SIZE-1:0] FramAdd,
   output logic                   FramEn,
   output logic                   Busy,
   output logic                   Done,
   output logic                   LenErr,
   output logic                   KeepErr,
   output logic [15:0]            FrameCnt
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Index of the final sample of a correctly sized frame.
   localparam logic [LENGTH_SIZE:0] LAST_IDX = (LENGTH_SIZE+1)'(LENGTH - 1);

   state_t                 state_r;
   state_t                 state_s;
   logic [LENGTH_SIZE:0]   count_r;
   logic [DATA_SIZE-1:0]   fram_data_r;
   logic [LENGTH_SIZE-1:0] fram_add_r;
   logic                   fram_en_r;
   logic                   done_r;
   logic                   len_err_r;
   logic                   keep_err_r;
   logic [15:0]            frame_cnt_r;

   logic tready_s;
   logic accept_s;
   logic start_s;
   logic at_last_s;
   logic recv_acc_s;
   logic drain_acc_s;
   logic frame_end_s;
   logic len_err_set_s;
   logic unused_s;

   // Abort also closes tready in its own cycle so no beat is consumed that
   // could never be written; otherwise tready follows state and FramStall.
   assign tready_s = !Abort &&
                     (((state_r == ST_RECV) && !FramStall) || (state_r == ST_DRAIN));
   assign accept_s      = S_AXIS_tvalid && tready_s;
   assign start_s       = Start && !Abort && (state_r == ST_IDLE);
   assign at_last_s     = (count_r == LAST_IDX);
   assign recv_acc_s    = accept_s && (state_r == ST_RECV);
   assign drain_acc_s   = accept_s && (state_r == ST_DRAIN);
   assign frame_end_s   = (recv_acc_s || drain_acc_s) && S_AXIS_tlast;
   // Short frame: tlast before the final index. Long frame: final index without tlast.
   assign len_err_set_s = recv_acc_s && (S_AXIS_tlast != at_last_s);
   assign unused_s      = ^S_AXIS_tdata[31:DATA_SIZE];

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_s) begin
               state_s = ST_RECV;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RECV: begin
            if (Abort) begin
               state_s = ST_IDLE;
            end else if (recv_acc_s && S_AXIS_tlast) begin
               state_s = ST_IDLE;
            end else if (recv_acc_s && at_last_s) begin
               state_s = ST_DRAIN;
            end else begin
               state_s = ST_RECV;
            end
         end
         ST_DRAIN: begin
            if (Abort) begin
               state_s = ST_IDLE;
            end else if (drain_acc_s && S_AXIS_tlast) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Frame-memory write port, Done pulse and frame counter.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fram_data_r <= {DATA_SIZE{1'b0}};
         fram_add_r  <= {LENGTH_SIZE{1'b0}};
         fram_en_r   <= 1'b0;
         done_r      <= 1'b0;
         frame_cnt_r <= 16'd0;
      end else begin
         fram_en_r <= recv_acc_s;
         done_r    <= frame_end_s;
         if (recv_acc_s) begin
            fram_data_r <= S_AXIS_tdata[DATA_SIZE-1:0];
            fram_add_r  <= count_r[LENGTH_SIZE-1:0];
         end else begin
            fram_data_r <= fram_data_r;
            fram_add_r  <= fram_add_r;
         end
         if (frame_end_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
         end else begin
            frame_cnt_r <= frame_cnt_r;
         end
      end
   end

   // Sample counter and sticky error flags; Start clears them for a new frame.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_r    <= {(LENGTH_SIZE+1){1'b0}};
         len_err_r  <= 1'b0;
         keep_err_r <= 1'b0;
      end else if (start_s) begin
         count_r    <= {(LENGTH_SIZE+1){1'b0}};
         len_err_r  <= 1'b0;
         keep_err_r <= 1'b0;
      end else begin
         if (recv_acc_s) begin
            count_r <= count_r + {{LENGTH_SIZE{1'b0}}, 1'b1};
         end else begin
            count_r <= count_r;
         end
         if (len_err_set_s) begin
            len_err_r <= 1'b1;
         end else begin
            len_err_r <= len_err_r;
         end
         if (accept_s && (S_AXIS_tkeep != 4'hF)) begin
            keep_err_r <= 1'b1;
         end else begin
            keep_err_r <= keep_err_r;
         end
      end
   end

   assign S_AXIS_tready = tready_s;
   assign FramData      = fram_data_r;
   assign FramAdd       = fram_add_r;
   assign FramEn        = fram_en_r;
   assign Busy          = (state_r != ST_IDLE);
   assign Done          = done_r;
   assign LenErr        = len_err_r;
   assign KeepErr       = keep_err_r;
   assign FrameCnt      = frame_cnt_r;

endmodule

// File: tb/tb_axis_frame_rx.sv
// Directed testbench for axis_frame_rx with LENGTH=256.
module tb_axis_frame_rx;

   localparam int DW = 12;
   localparam int LEN = 256;
   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          rstn;
   logic          Start, Abort;
   logic [31:0]   S_AXIS_tdata;
   logic [3:0]    S_AXIS_tkeep;
   logic          S_AXIS_tlast, S_AXIS_tvalid, S_AXIS_tready;
   logic          FramStall;
   logic [DW-1:0] FramData;
   logic [LW-1:0] FramAdd;
   logic          FramEn, Busy, Done, LenErr, KeepErr;
   logic [15:0]   FrameCnt;

   int n_checks = 0;
   int n_pass = 0;

   logic [LW-1:0] wr_addr[$];
   logic [DW-1:0] wr_data[$];
   int            done_cnt;
   logic          done_with_en;
   logic [LW-1:0] done_addr;

   axis_frame_rx #(.DATA_SIZE(DW), .LENGTH(LEN), .LENGTH_SIZE(LW)) dut (
      .clk(clk), .rstn(rstn), .Start(Start), .Abort(Abort),
      .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tkeep(S_AXIS_tkeep),
      .S_AXIS_tlast(S_AXIS_tlast), .S_AXIS_tvalid(S_AXIS_tvalid),
      .S_AXIS_tready(S_AXIS_tready), .FramStall(FramStall),
      .FramData(FramData), .FramAdd(FramAdd), .FramEn(FramEn),
      .Busy(Busy), .Done(Done), .LenErr(LenErr), .KeepErr(KeepErr),
      .FrameCnt(FrameCnt)
   );

   always #5 clk = ~clk;

   // Write/Done monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (FramEn) begin
         wr_addr.push_back(FramAdd);
         wr_data.push_back(FramData);
      end
      if (Done) begin
         done_cnt     = done_cnt + 1;
         done_with_en = FramEn;
         done_addr    = FramAdd;
      end
   end

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      done_cnt = 0;
      done_with_en = 1'b0;
      done_addr = '0;
   endtask

   function automatic logic [DW-1:0] sample(input int base, input int i);
      return DW'((base + i) % 4096);
   endfunction

   task automatic pulse_start();
      Start = 1'b1;
      @(posedge clk); #1;
      Start = 1'b0;
   endtask

   task automatic pulse_abort();
      Abort = 1'b1;
      @(posedge clk); #1;
      Abort = 1'b0;
   endtask

   // Sends n beats; tlast on index last_at, bad tkeep on index bad_keep (-1 = none).
   task automatic send_beats(input int n, input int last_at, input int bad_keep,
                             input int base, input bit rnd);
      for (int i = 0; i < n; i++) begin
         bit acc = 1'b0;
         int guard = 0;
         while (!acc && guard < 200) begin
            S_AXIS_tvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            FramStall     = rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
            S_AXIS_tdata  = {20'hABCDE, sample(base, i)};
            S_AXIS_tlast  = (i == last_at);
            S_AXIS_tkeep  = (i == bad_keep) ? 4'h7 : 4'hF;
            @(negedge clk);
            acc = S_AXIS_tvalid && S_AXIS_tready;
            @(posedge clk); #1;
            guard++;
         end
         if (!acc) begin
            n_checks++;
            $display("FAIL beat_timeout: beat %0d not accepted within 200 cycles", i);
            break;
         end
      end
      S_AXIS_tvalid = 1'b0;
      S_AXIS_tlast  = 1'b0;
      S_AXIS_tkeep  = 4'hF;
      FramStall     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      Start = 1'b0; Abort = 1'b0; S_AXIS_tdata = '0; S_AXIS_tkeep = 4'hF;
      S_AXIS_tlast = 1'b0; S_AXIS_tvalid = 1'b1; FramStall = 1'b0;
      clear_log();
      rstn = 1'b0;
      #3;
      n_checks++;
      if ({S_AXIS_tready, FramEn, Busy, Done, LenErr, KeepErr} !== 6'b0)
         $display("FAIL reset_flags: got %b want 000000",
                  {S_AXIS_tready, FramEn, Busy, Done, LenErr, KeepErr});
      else n_pass++;
      n_checks++;
      if ({FramData, FramAdd, FrameCnt} !== 36'd0)
         $display("FAIL reset_values: data %h addr %h cnt %h want 0", FramData, FramAdd, FrameCnt);
      else n_pass++;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (S_AXIS_tready !== 1'b0) $display("FAIL idle_tready: got %b want 0", S_AXIS_tready);
      else n_pass++;
      @(posedge clk); #1;
      S_AXIS_tvalid = 1'b0;
   endtask

   task automatic test_good_frame();
      int bad = 0;
      clear_log();
      pulse_start();
      n_checks++;
      if (Busy !== 1'b1) $display("FAIL good_busy: got %b want 1", Busy);
      else n_pass++;
      send_beats(256, 255, -1, 0, 1'b0);
      foreach (wr_addr[i])
         if (wr_addr[i] !== LW'(i) || wr_data[i] !== sample(0, i)) bad++;
      n_checks++;
      if (wr_addr.size() != 256 || bad != 0)
         $display("FAIL good_writes: got %0d writes %0d wrong want 256 writes 0 wrong", wr_addr.size(), bad);
      else n_pass++;
      n_checks++;
      if (done_cnt != 1 || done_with_en !== 1'b1 || done_addr !== 8'd255)
         $display("FAIL good_done: got cnt %0d en %b addr %0d want 1 1 255", done_cnt, done_with_en, done_addr);
      else n_pass++;
      n_checks++;
      if ({LenErr, KeepErr, Busy} !== 3'b000 || FrameCnt !== 16'd1)
         $display("FAIL good_status: got lenerr %b keeperr %b busy %b cnt %0d want 0 0 0 1",
                  LenErr, KeepErr, Busy, FrameCnt);
      else n_pass++;
   endtask

   task automatic test_short_frame();
      int bad = 0;
      clear_log();
      pulse_start();
      send_beats(100, 99, -1, 'h100, 1'b0);
      foreach (wr_addr[i])
         if (wr_addr[i] !== LW'(i) || wr_data[i] !== sample('h100, i)) bad++;
      n_checks++;
      if (wr_addr.size() != 100 || bad != 0)
         $display("FAIL short_writes: got %0d writes %0d wrong want 100 writes 0 wrong", wr_addr.size(), bad);
      else n_pass++;
      n_checks++;
      if (done_cnt != 1 || done_with_en !== 1'b1 || done_addr !== 8'd99)
         $display("FAIL short_done: got cnt %0d en %b addr %0d want 1 1 99", done_cnt, done_with_en, done_addr);
      else n_pass++;
      n_checks++;
      if (LenErr !== 1'b1 || Busy !== 1'b0 || FrameCnt !== 16'd2)
         $display("FAIL short_status: got lenerr %b busy %b cnt %0d want 1 0 2", LenErr, Busy, FrameCnt);
      else n_pass++;
   endtask

   task automatic test_long_frame();
      clear_log();
      pulse_start();
      n_checks++;
      if (LenErr !== 1'b0) $display("FAIL start_clears_lenerr: got %b want 0", LenErr);
      else n_pass++;
      send_beats(260, -1, -1, 'h200, 1'b0);
      n_checks++;
      if (Busy !== 1'b1 || wr_addr.size() != 256 || LenErr !== 1'b1 || done_cnt != 0)
         $display("FAIL long_drain: got busy %b writes %0d lenerr %b done %0d want 1 256 1 0",
                  Busy, wr_addr.size(), LenErr, done_cnt);
      else n_pass++;
      send_beats(40, 39, -1, 'h300, 1'b0);
      n_checks++;
      if (wr_addr.size() != 256 || wr_addr[255] !== 8'd255 || wr_data[255] !== sample('h200, 255))
         $display("FAIL long_writes: got %0d writes want 256", wr_addr.size());
      else n_pass++;
      n_checks++;
      if (done_cnt != 1 || done_with_en !== 1'b0 || Busy !== 1'b0 || FrameCnt !== 16'd3)
         $display("FAIL long_done: got cnt %0d en %b busy %b frames %0d want 1 0 0 3",
                  done_cnt, done_with_en, Busy, FrameCnt);
      else n_pass++;
   endtask

   task automatic test_stall_gaps();
      int bad = 0;
      clear_log();
      pulse_start();
      send_beats(256, 255, -1, 'h555, 1'b1);
      foreach (wr_addr[i])
         if (wr_addr[i] !== LW'(i) || wr_data[i] !== sample('h555, i)) bad++;
      n_checks++;
      if (wr_addr.size() != 256 || bad != 0)
         $display("FAIL stall_writes: got %0d writes %0d wrong want 256 writes 0 wrong", wr_addr.size(), bad);
      else n_pass++;
      n_checks++;
      if (done_cnt != 1 || LenErr !== 1'b0 || FrameCnt !== 16'd4)
         $display("FAIL stall_status: got done %0d lenerr %b cnt %0d want 1 0 4", done_cnt, LenErr, FrameCnt);
      else n_pass++;
   endtask

   task automatic test_keep_err();
      clear_log();
      pulse_start();
      send_beats(256, 255, 10, 'h0F0, 1'b0);
      n_checks++;
      if (KeepErr !== 1'b1 || LenErr !== 1'b0)
         $display("FAIL keep_flag: got keeperr %b lenerr %b want 1 0", KeepErr, LenErr);
      else n_pass++;
      n_checks++;
      if (wr_addr.size() != 256 || wr_addr[10] !== 8'd10 || wr_data[10] !== sample('h0F0, 10))
         $display("FAIL keep_sample10: got %0d writes data10 %h want 256 %h",
                  wr_addr.size(), wr_data[10], sample('h0F0, 10));
      else n_pass++;
      pulse_start();
      n_checks++;
      if (KeepErr !== 1'b0 || Busy !== 1'b1)
         $display("FAIL keep_clear: got keeperr %b busy %b want 0 1", KeepErr, Busy);
      else n_pass++;
      pulse_abort();
      n_checks++;
      if (Busy !== 1'b0 || FrameCnt !== 16'd5)
         $display("FAIL keep_abort: got busy %b cnt %0d want 0 5", Busy, FrameCnt);
      else n_pass++;
   endtask

   task automatic test_abort();
      int bad = 0;
      clear_log();
      pulse_start();
      send_beats(50, -1, -1, 'h700, 1'b0);
      pulse_abort();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (Busy !== 1'b0 || done_cnt != 0 || FrameCnt !== 16'd5 || wr_addr.size() != 50)
         $display("FAIL abort_state: got busy %b done %0d cnt %0d writes %0d want 0 0 5 50",
                  Busy, done_cnt, FrameCnt, wr_addr.size());
      else n_pass++;
      S_AXIS_tvalid = 1'b1;
      @(negedge clk);
      n_checks++;
      if (S_AXIS_tready !== 1'b0 || FramEn !== 1'b0)
         $display("FAIL abort_idle: got tready %b framen %b want 0 0", S_AXIS_tready, FramEn);
      else n_pass++;
      @(posedge clk); #1;
      S_AXIS_tvalid = 1'b0;
      Start = 1'b1; Abort = 1'b1;
      @(posedge clk); #1;
      Start = 1'b0; Abort = 1'b0;
      n_checks++;
      if (Busy !== 1'b0) $display("FAIL abort_wins: got busy %b want 0", Busy);
      else n_pass++;
      clear_log();
      pulse_start();
      send_beats(256, 255, -1, 'h800, 1'b0);
      foreach (wr_addr[i])
         if (wr_addr[i] !== LW'(i) || wr_data[i] !== sample('h800, i)) bad++;
      n_checks++;
      if (wr_addr.size() != 256 || bad != 0 || done_cnt != 1 || FrameCnt !== 16'd6)
         $display("FAIL abort_refill: got writes %0d wrong %0d done %0d cnt %0d want 256 0 1 6",
                  wr_addr.size(), bad, done_cnt, FrameCnt);
      else n_pass++;
   endtask

   task automatic test_reset_midframe();
      pulse_start();
      send_beats(20, -1, -1, 0, 1'b0);
      #2 rstn = 1'b0;
      #1;
      n_checks++;
      if (Busy !== 1'b0 || FrameCnt !== 16'd0 || FramEn !== 1'b0 || FramAdd !== 8'd0)
         $display("FAIL midreset_async: got busy %b cnt %0d framen %b addr %0d want 0 0 0 0",
                  Busy, FrameCnt, FramEn, FramAdd);
      else n_pass++;
      @(posedge clk); #1 rstn = 1'b1;
      S_AXIS_tvalid = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (S_AXIS_tready !== 1'b0 || Busy !== 1'b0)
         $display("FAIL midreset_idle: got tready %b busy %b want 0 0", S_AXIS_tready, Busy);
      else n_pass++;
      S_AXIS_tvalid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_short_frame();
      test_long_frame();
      test_stall_gaps();
      test_keep_err();
      test_abort();
      test_reset_midframe();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
